// File: rtl/md5_msg_padder.sv
// MD5 message padder: byte-stream beats in, padded 512-bit blocks out as 16 little-endian words.
// Optional macro MD5_PAD_LEN_OVF_EN enables the sticky bit-length overflow flag err_len_ovf.
module md5_msg_padder #(
   parameter int IN_BYTES = 4,
   parameter int LEN_W    = 64
) (
   input  logic                       Clk,
   input  logic                       Rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [8*IN_BYTES-1:0]      in_data,
   input  logic                       in_last,
   input  logic [$clog2(IN_BYTES):0]  in_nbytes,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [31:0]                out_data,
   output logic                       out_block_last,
   output logic                       out_msg_last,
   output logic                       err_len_ovf
);

   localparam logic [2:0] S_DATA  = 3'd0;
   localparam logic [2:0] S_FLUSH = 3'd1;
   localparam logic [2:0] S_ZERO  = 3'd2;
   localparam logic [2:0] S_LEN0  = 3'd3;
   localparam logic [2:0] S_LEN1  = 3'd4;
   localparam int         NB_W    = $clog2(IN_BYTES) + 1;

   // Byte count of a final beat, saturated to the beat width.
   function automatic logic [3:0] sat_nbytes(input logic [NB_W-1:0] nb);
      if (4'(nb) > 4'(IN_BYTES)) return 4'(IN_BYTES);
      return 4'(nb);
   endfunction

   logic [2:0]       state_p0;
   logic [7:0]       sbuf_p0 [8];
   logic [3:0]       cnt_p0;
   logic [3:0]       idx_p0;
   logic [LEN_W-1:0] len_p0;

   logic             beat, word, pop4, clr;
   logic [3:0]       nb, base, cnt_nxt;
   logic [7:0]       sbuf_nxt [8];
   logic [63:0]      len64;
   logic [LEN_W-1:0] len_sum;

   assign len64 = 64'(len_p0);

   always_comb begin
      in_ready  = (state_p0 == S_DATA) && (cnt_p0 < 4'd4) && !Rst;
      out_valid = 1'b0;
      out_data  = '0;
      case (state_p0)
         S_DATA: begin
            out_valid = (cnt_p0 >= 4'd4);
            out_data  = {sbuf_p0[3], sbuf_p0[2], sbuf_p0[1], sbuf_p0[0]};
         end
         S_FLUSH: begin
            out_valid = 1'b1;
            if (cnt_p0 >= 4'd4) begin
               out_data = {sbuf_p0[3], sbuf_p0[2], sbuf_p0[1], sbuf_p0[0]};
            end else begin
               // Tail bytes, then the 0x80 marker, zeros above it.
               for (int k = 0; k < 4; k++) begin
                  if (4'(k) < cnt_p0)       out_data[8*k +: 8] = sbuf_p0[k];
                  else if (4'(k) == cnt_p0) out_data[8*k +: 8] = 8'h80;
               end
            end
         end
         S_ZERO: out_valid = 1'b1;
         S_LEN0: begin
            out_valid = 1'b1;
            out_data  = len64[31:0];
         end
         S_LEN1: begin
            out_valid = 1'b1;
            out_data  = len64[63:32];
         end
         default: ;
      endcase
      if (Rst) out_valid = 1'b0;
   end

   assign out_block_last = out_valid && (idx_p0 == 4'd15);
   assign out_msg_last   = out_valid && (state_p0 == S_LEN1);

   always_comb begin
      beat    = in_valid && in_ready;
      word    = out_valid && out_ready;
      pop4    = word && ((state_p0 == S_DATA) || ((state_p0 == S_FLUSH) && (cnt_p0 >= 4'd4)));
      clr     = word && (state_p0 == S_FLUSH) && (cnt_p0 < 4'd4);
      nb      = in_last ? sat_nbytes(in_nbytes) : 4'(IN_BYTES);
      base    = pop4 ? (cnt_p0 - 4'd4) : (clr ? 4'd0 : cnt_p0);
      cnt_nxt = base + (beat ? nb : 4'd0);
      for (int k = 0; k < 8; k++) sbuf_nxt[k] = sbuf_p0[k];
      if (pop4) begin
         for (int k = 0; k < 4; k++) sbuf_nxt[k] = sbuf_p0[k+4];
      end
      // New bytes land just above whatever survives the pop.
      if (beat) begin
         for (int k = 0; k < IN_BYTES; k++) sbuf_nxt[3'(base + 4'(k))] = in_data[8*k +: 8];
      end
   end

`ifdef MD5_PAD_LEN_OVF_EN
   logic [LEN_W:0] len_add;
   logic           err_p0;
   assign len_add     = {1'b0, len_p0} + (LEN_W+1)'({nb, 3'b000});
   assign len_sum     = len_add[LEN_W-1:0];
   assign err_len_ovf = err_p0;

   always_ff @(posedge Clk) begin
      if (Rst)                       err_p0 <= 1'b0;
      else if (beat && len_add[LEN_W]) err_p0 <= 1'b1;
   end
`else
   assign len_sum     = len_p0 + LEN_W'({nb, 3'b000});
   assign err_len_ovf = 1'b0;
`endif

   // ---- buffer / control registers ----
   always_ff @(posedge Clk) begin
      sbuf_p0 <= sbuf_nxt;
      if (Rst) begin
         state_p0 <= S_DATA;
         cnt_p0   <= '0;
         idx_p0   <= '0;
         len_p0   <= '0;
      end else begin
         cnt_p0 <= cnt_nxt;
         if (beat) len_p0 <= len_sum;
         if (word) idx_p0 <= idx_p0 + 4'd1;
         case (state_p0)
            S_DATA:  if (beat && in_last) state_p0 <= S_FLUSH;
            S_FLUSH: if (clr) state_p0 <= (idx_p0 == 4'd13) ? S_LEN0 : S_ZERO;
            S_ZERO:  if (word && (idx_p0 == 4'd13)) state_p0 <= S_LEN0;
            S_LEN0:  if (word) state_p0 <= S_LEN1;
            S_LEN1: begin
               if (word) begin
                  state_p0 <= S_DATA;
                  len_p0   <= '0;
                  idx_p0   <= '0;
               end
            end
            default: state_p0 <= S_DATA;
         endcase
      end
   end

endmodule

// File: tb/tb_md5_msg_padder.sv
// Directed bench for md5_msg_padder; a second instance with LEN_W=8 covers length wrap
// and, when MD5_PAD_LEN_OVF_EN is defined, the overflow flag.
module tb_md5_msg_padder;

`ifdef MD5_PAD_LEN_OVF_EN
   localparam logic EXP_ERR8 = 1'b1;
`else
   localparam logic EXP_ERR8 = 1'b0;
`endif

   logic        Clk = 1'b0;
   logic        Rst;
   logic        in_valid, in_last, out_ready;
   logic [31:0] in_data;
   logic [2:0]  in_nbytes;
   logic        in_ready, out_valid, out_block_last, out_msg_last, err_len_ovf;
   logic [31:0] out_data;
   logic        in_ready8, out_valid8, bl8, ml8, err8;
   logic [31:0] out_data8;

   int          n_asrt = 0;
   int          n_fail = 0;
   int          msg_done = 0;
   int          rdy_mode = 0;
   int          rcnt = 0;
   logic        busy = 1'b0;
   logic        stall_pend = 1'b0;
   logic [31:0] stall_data = '0;
   logic [31:0] got_d [$];
   logic        got_bl [$];
   logic        got_ml [$];
   logic [31:0] g8 [$];

   always #5 Clk = ~Clk;

   md5_msg_padder #(.IN_BYTES(4), .LEN_W(64)) u_dut (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_nbytes(in_nbytes), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_block_last(out_block_last), .out_msg_last(out_msg_last),
      .err_len_ovf(err_len_ovf));

   md5_msg_padder #(.IN_BYTES(4), .LEN_W(8)) u_dut8 (
      .Clk(Clk), .Rst(Rst), .in_valid(in_valid), .in_ready(in_ready8), .in_data(in_data),
      .in_last(in_last), .in_nbytes(in_nbytes), .out_valid(out_valid8), .out_ready(out_ready),
      .out_data(out_data8), .out_block_last(bl8), .out_msg_last(ml8),
      .err_len_ovf(err8));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Downstream ready: 0 = always, 1 = 1,0,0 repeating, 2 = never.
   always @(posedge Clk) begin
      #1;
      rcnt++;
      case (rdy_mode)
         1:       out_ready = (rcnt % 3 == 0);
         2:       out_ready = 1'b0;
         default: out_ready = 1'b1;
      endcase
   end

   always @(negedge Clk) begin
      if (Rst) begin
         stall_pend = 1'b0;
      end else begin
         if (stall_pend) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", out_data, stall_data);
         end
         stall_pend = out_valid && !out_ready;
         stall_data = out_data;
         if (busy) chk("in_ready_busy", 32'(in_ready), 32'd0);
         if (out_valid && out_ready) begin
            got_d.push_back(out_data);
            got_bl.push_back(out_block_last);
            got_ml.push_back(out_msg_last);
            if (out_msg_last) begin
               msg_done++;
               busy = 1'b0;
            end
         end
         if (out_valid8 && out_ready) g8.push_back(out_data8);
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic last, input logic [2:0] nb);
      int g = 0;
      in_data = d; in_last = last; in_nbytes = nb; in_valid = 1'b1;
      @(negedge Clk);
      while (!in_ready && g < 100) begin
         @(negedge Clk);
         g++;
      end
      chk("beat_accept", 32'(in_ready), 32'd1);
      @(posedge Clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
      if (last) busy = 1'b1;
   endtask

   task automatic send_bytes(input int n);
      logic [31:0] d;
      for (int i = 0; i < n; i += 4) begin
         for (int k = 0; k < 4; k++) d[8*k +: 8] = 8'(i + k);
         send_beat(d, (i + 4 >= n), 3'(n - i > 4 ? 4 : n - i));
      end
   endtask

   task automatic wait_done(input int target);
      int g = 0;
      while (msg_done < target && g < 400) begin
         @(negedge Clk);
         g++;
      end
      chk("msg_done", 32'(msg_done), 32'(target));
      @(posedge Clk); #1;
   endtask

   task automatic clear_q();
      got_d.delete(); got_bl.delete(); got_ml.delete(); g8.delete();
   endtask

   task automatic check_abc(input string tag);
      int nbl = 0;
      chk({tag, "_nwords"}, 32'(got_d.size()), 32'd16);
      if (got_d.size() == 16) begin
         chk({tag, "_w0"}, got_d[0], 32'h80636261);
         for (int i = 1; i < 14; i++) chk({tag, "_zero"}, got_d[i], 32'h0);
         chk({tag, "_w14"}, got_d[14], 32'h00000018);
         chk({tag, "_w15"}, got_d[15], 32'h0);
         for (int i = 0; i < 16; i++) nbl += int'(got_bl[i]);
         chk({tag, "_nblock_last"}, 32'(nbl), 32'd1);
         chk({tag, "_bl15"}, 32'(got_bl[15]), 32'd1);
         chk({tag, "_ml15"}, 32'(got_ml[15]), 32'd1);
         chk({tag, "_ml14"}, 32'(got_ml[14]), 32'd0);
      end
   endtask

   initial begin
      int nbl;
      Rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0; in_nbytes = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      @(posedge Clk); #1;
      Rst = 1'b0;
      @(negedge Clk);
      chk("idle_in_ready", 32'(in_ready), 32'd1);
      chk("idle_out_valid", 32'(out_valid), 32'd0);
      chk("idle_block_last", 32'(out_block_last), 32'd0);
      chk("idle_msg_last", 32'(out_msg_last), 32'd0);
      chk("idle_err", 32'(err_len_ovf), 32'd0);
      @(posedge Clk); #1;

      // "abc" with a junk 4th byte that must be replaced by the pad marker.
      clear_q();
      send_beat(32'hEE636261, 1'b1, 3'd3);
      wait_done(1);
      check_abc("abc");

      // Empty message.
      clear_q();
      send_beat(32'hDEADBEEF, 1'b1, 3'd0);
      wait_done(2);
      chk("empty_nwords", 32'(got_d.size()), 32'd16);
      if (got_d.size() == 16) begin
         chk("empty_w0", got_d[0], 32'h00000080);
         for (int i = 1; i < 16; i++) chk("empty_zero", got_d[i], 32'h0);
         chk("empty_ml15", 32'(got_ml[15]), 32'd1);
      end

      // 56 bytes: pad at index 14 spills the length into a second block.
      clear_q();
      send_bytes(56);
      wait_done(3);
      chk("b56_nwords", 32'(got_d.size()), 32'd32);
      if (got_d.size() == 32) begin
         chk("b56_w0", got_d[0], 32'h03020100);
         chk("b56_w13", got_d[13], 32'h37363534);
         for (int i = 1; i < 13; i++)
            chk("b56_data", got_d[i], {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
         chk("b56_w14", got_d[14], 32'h00000080);
         chk("b56_w15", got_d[15], 32'h0);
         for (int i = 16; i < 30; i++) chk("b56_zero", got_d[i], 32'h0);
         chk("b56_len_lo", got_d[30], 32'h000001C0);
         chk("b56_len_hi", got_d[31], 32'h0);
         nbl = 0;
         for (int i = 0; i < 32; i++) nbl += int'(got_bl[i]);
         chk("b56_nblock_last", 32'(nbl), 32'd2);
         chk("b56_bl15", 32'(got_bl[15]), 32'd1);
         chk("b56_ml31", 32'(got_ml[31]), 32'd1);
      end

      // "abc" under back-pressure.
      clear_q();
      rdy_mode = 1;
      send_beat(32'h00636261, 1'b1, 3'd3);
      wait_done(4);
      check_abc("abc_bp");
      rdy_mode = 0;

      // Abort a partially buffered message with Rst, then send "abc".
      rdy_mode = 2;
      @(posedge Clk); #2;
      send_beat(32'h44332211, 1'b0, 3'd4);
      repeat (2) @(posedge Clk);
      #1;
      Rst = 1'b1;
      repeat (2) @(posedge Clk);
      #1;
      clear_q();
      rdy_mode = 0;
      Rst = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      chk("abort_no_words", 32'(got_d.size()), 32'd0);
      send_beat(32'h00636261, 1'b1, 3'd3);
      wait_done(5);
      check_abc("abort_abc");

      // 32 bytes: 256 bits wraps an 8-bit length counter on the last beat.
      clear_q();
      chk("ovf_err8_pre", 32'(err8), 32'd0);
      for (int b = 0; b < 8; b++) begin
         send_beat({8'(4*b+3), 8'(4*b+2), 8'(4*b+1), 8'(4*b)}, (b == 7), 3'd4);
         if (b == 6) chk("ovf_err8_b28", 32'(err8), 32'd0);
      end
      chk("ovf_err8_b32", 32'(err8), 32'(EXP_ERR8));
      chk("ovf_err64", 32'(err_len_ovf), 32'd0);
      wait_done(6);
      chk("ovf_nwords", 32'(got_d.size()), 32'd16);
      if (got_d.size() == 16) begin
         chk("ovf_w7", got_d[7], 32'h1F1E1D1C);
         chk("ovf_pad", got_d[8], 32'h00000080);
         chk("ovf_len64", got_d[14], 32'h00000100);
      end
      chk("ovf8_nwords", 32'(g8.size()), 32'd16);
      if (g8.size() == 16) chk("ovf8_len", g8[14], 32'h0);
      chk("ovf_err8_sticky", 32'(err8), 32'(EXP_ERR8));

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
